// File: rtl/decoder_seq.sv
// decoder_seq: registered N-to-2**N one-hot decoder with a valid/ready request
// handshake and an optional one-hot sweep of every output bit.
// Optional sweep build: define DECODER_SEQ_SCAN_EN. Without it only the
// decoder is built; scan_start is ignored and ready_o is constantly 1.
//
// state | meaning
// IDLE  | decode requests accepted; scan_start launches a sweep
// SCAN  | Y = 1 << idx, idx steps 0 .. 2**N-1, one bit per cycle
// DONE  | single cycle, Y = 0, scan_done pulses, then back to IDLE
module decoder_seq #(
  parameter int N    = 5,
  parameter bit HOLD = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    A,
  input  logic            enable,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            scan_start,
  output logic [2**N-1:0] Y,
  output logic            valid_o,
  output logic            scan_busy,
  output logic            scan_done
);

  localparam int W = 2**N;

  logic [W-1:0] dec;
  logic [W-1:0] y_nx;
  logic         valid_nx;
  logic         accept;

  // decoded value for the current request; a disabled decode yields zero
  assign dec = enable ? (W'(1) << A) : '0;

`ifdef DECODER_SEQ_SCAN_EN

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_nx;
  logic [N-1:0] idx, idx_nx;
  logic         busy_nx, done_nx;

  // a sweep start takes priority over a simultaneous request
  assign ready_o = (state == IDLE) && !scan_start;
  assign accept  = valid_i && ready_o;

  // next state, sweep index and next registered output values
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    y_nx     = HOLD ? Y : '0;
    valid_nx = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (scan_start) begin
          state_nx = SCAN;
          idx_nx   = '0;
          y_nx     = W'(1);
          busy_nx  = 1'b1;
        end else if (accept) begin
          y_nx     = dec;
          valid_nx = 1'b1;
        end
      end
      SCAN: begin
        // terminal index compared directly so idx never wraps back to 0
        if (idx == N'(W - 1)) begin
          state_nx = DONE;
          y_nx     = '0;
          done_nx  = 1'b1;
        end else begin
          idx_nx   = idx + 1'b1;
          y_nx     = W'(1) << (idx + 1'b1);
          busy_nx  = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        y_nx     = '0;
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
        y_nx     = '0;
      end
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      Y         <= '0;
      valid_o   <= 1'b0;
      scan_busy <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      Y         <= y_nx;
      valid_o   <= valid_nx;
      scan_busy <= busy_nx;
      scan_done <= done_nx;
    end
  end

`else

  logic unused_scan_start;

  assign unused_scan_start = scan_start;
  assign ready_o           = 1'b1;
  assign accept            = valid_i;
  assign scan_busy         = 1'b0;
  assign scan_done         = 1'b0;

  // next decode result: new value on acceptance, otherwise hold or clear
  always_comb begin
    y_nx     = HOLD ? Y : '0;
    valid_nx = 1'b0;
    if (accept) begin
      y_nx     = dec;
      valid_nx = 1'b1;
    end
  end

  // output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      Y       <= '0;
      valid_o <= 1'b0;
    end else begin
      Y       <= y_nx;
      valid_o <= valid_nx;
    end
  end

`endif

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: self-checking bench for decoder_seq. Four instances cover
// N=5/HOLD=0, N=5/HOLD=1, N=3 and N=4. Sweep checks are built only when
// DECODER_SEQ_SCAN_EN is defined; otherwise the scan-ignored behaviour is checked.
module tb_decoder_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // N=5 pair shares stimulus
  logic [4:0]  a5;
  logic        en5, v5, ss5;
  logic [31:0] y50, y51;
  logic        vo50, vo51, r50, r51, b50, b51, d50, d51;

  logic [2:0]  a3;
  logic        en3, v3, ss3;
  logic [7:0]  y3;
  logic        vo3, r3, b3, d3;

  logic [3:0]  a4;
  logic        en4, v4, ss4;
  logic [15:0] y4;
  logic        vo4, r4, b4, d4;

  int pass_cnt = 0;
  int total    = 0;

  decoder_seq #(.N(5), .HOLD(1'b0)) u5h0 (
    .clock(clk), .reset(rst), .A(a5), .enable(en5), .valid_i(v5), .ready_o(r50),
    .scan_start(ss5), .Y(y50), .valid_o(vo50), .scan_busy(b50), .scan_done(d50));

  decoder_seq #(.N(5), .HOLD(1'b1)) u5h1 (
    .clock(clk), .reset(rst), .A(a5), .enable(en5), .valid_i(v5), .ready_o(r51),
    .scan_start(ss5), .Y(y51), .valid_o(vo51), .scan_busy(b51), .scan_done(d51));

  decoder_seq #(.N(3), .HOLD(1'b0)) u3 (
    .clock(clk), .reset(rst), .A(a3), .enable(en3), .valid_i(v3), .ready_o(r3),
    .scan_start(ss3), .Y(y3), .valid_o(vo3), .scan_busy(b3), .scan_done(d3));

  decoder_seq #(.N(4), .HOLD(1'b0)) u4 (
    .clock(clk), .reset(rst), .A(a4), .enable(en4), .valid_i(v4), .ready_o(r4),
    .scan_start(ss4), .Y(y4), .valid_o(vo4), .scan_busy(b4), .scan_done(d4));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // advance one clock and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0]  a;
    logic        en;
    logic [31:0] exp_y;
  } vec_t;

  vec_t vecs[6];

  logic [63:0] m_y0, m_y1;
  logic        m_vo;
  logic [7:0]  e3;

  initial begin
    vecs[0] = '{5'd0,  1'b1, 32'h0000_0001};
    vecs[1] = '{5'd31, 1'b1, 32'h8000_0000};
    vecs[2] = '{5'd7,  1'b0, 32'h0000_0000};
    vecs[3] = '{5'd16, 1'b1, 32'h0001_0000};
    vecs[4] = '{5'd1,  1'b1, 32'h0000_0002};
    vecs[5] = '{5'd20, 1'b1, 32'h0010_0000};

    rst = 1'b1;
    a5 = '0; en5 = 0; v5 = 0; ss5 = 0;
    a3 = '0; en3 = 0; v3 = 0; ss3 = 0;
    a4 = '0; en4 = 0; v4 = 0; ss4 = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // reset state
    check("rst_y50", y50, 0);
    check("rst_vo50", vo50, 0);
    check("rst_y51", y51, 0);
    check("rst_y3", y3, 0);
    check("rst_busy3", b3, 0);
    check("rst_done3", d3, 0);
    check("rst_ready3", r3, 1);
    check("rst_ready50", r50, 1);

    // single request A=7, one-cycle pulse with HOLD=0
    a5 = 5'd7; en5 = 1; v5 = 1;
    tick();
    v5 = 0;
    check("a7_y", y50, 32'h0000_0080);
    check("a7_vo", vo50, 1);
    tick();
    check("a7_y_after", y50, 0);
    check("a7_vo_after", vo50, 0);
    check("a7_hold_y", y51, 32'h0000_0080);

    // table vectors: HOLD=0 pulses, HOLD=1 retains
    for (int i = 0; i < 6; i++) begin
      a5 = vecs[i].a; en5 = vecs[i].en; v5 = 1;
      tick();
      v5 = 0;
      check($sformatf("vec%0d_y0", i), y50, vecs[i].exp_y);
      check($sformatf("vec%0d_vo0", i), vo50, 1);
      check($sformatf("vec%0d_y1", i), y51, vecs[i].exp_y);
      tick();
      check($sformatf("vec%0d_y0_idle", i), y50, 0);
      check($sformatf("vec%0d_vo0_idle", i), vo50, 0);
      check($sformatf("vec%0d_y1_held", i), y51, vecs[i].exp_y);
      check($sformatf("vec%0d_vo1_idle", i), vo51, 0);
    end

    // HOLD=1: A=3 held 4 idle cycles, then disabled request clears it
    a5 = 5'd3; en5 = 1; v5 = 1;
    tick();
    v5 = 0;
    check("hold_a3_y", y51, 32'h0000_0008);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("hold_idle%0d_y", i), y51, 32'h0000_0008);
      check($sformatf("hold_idle%0d_vo", i), vo51, 0);
    end
    a5 = 5'd3; en5 = 0; v5 = 1;
    tick();
    v5 = 0;
    check("hold_dis_y", y51, 0);
    check("hold_dis_vo", vo51, 1);

    // randomized requests against a behavioural model of both N=5 variants
    m_y1 = {32'd0, y51};
    for (int i = 0; i < 200; i++) begin
      a5  = 5'($urandom_range(0, 31));
      en5 = 1'($urandom_range(0, 3) != 0);
      v5  = 1'($urandom_range(0, 1));
      #1;
      check("rnd_ready", r50, 1);
      if (v5) begin
        m_y0 = en5 ? (64'd1 << a5) : 64'd0;
        m_y1 = m_y0;
      end else begin
        m_y0 = 64'd0;
      end
      m_vo = v5;
      tick();
      check("rnd_y0", y50, m_y0);
      check("rnd_y1", y51, m_y1);
      check("rnd_vo0", vo50, m_vo);
      check("rnd_vo1", vo51, m_vo);
    end
    v5 = 0;

`ifdef DECODER_SEQ_SCAN_EN
    // full sweep on N=3
    ss3 = 1;
    #1;
    check("sw_ready_start", r3, 0);
    tick();
    ss3 = 0;
    for (int i = 0; i < 8; i++) begin
      e3 = 8'd1 << i;
      check($sformatf("sw_y%0d", i), y3, e3);
      check($sformatf("sw_busy%0d", i), b3, 1);
      check($sformatf("sw_done%0d", i), d3, 0);
      check($sformatf("sw_vo%0d", i), vo3, 0);
      check($sformatf("sw_ready%0d", i), r3, 0);
      tick();
    end
    check("sw_done_y", y3, 0);
    check("sw_done", d3, 1);
    check("sw_done_busy", b3, 0);
    check("sw_done_ready", r3, 0);
    tick();
    check("sw_idle_done", d3, 0);
    check("sw_idle_ready", r3, 1);
    check("sw_idle_y", y3, 0);

    // scan_start beats a simultaneous request; requests ignored mid-sweep
    ss3 = 1; v3 = 1; a3 = 3'd5; en3 = 1;
    tick();
    ss3 = 0;
    check("col_y", y3, 8'h01);
    check("col_vo", vo3, 0);
    check("col_busy", b3, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("col_vo_c%0d", i), vo3, 0);
    end
    check("col_done", d3, 1);
    v3 = 0;
    tick();
    check("col_end_vo", vo3, 0);
    check("col_end_y", y3, 0);

    // reset mid-sweep aborts without a done pulse
    ss3 = 1;
    tick();
    ss3 = 0;
    repeat (4) tick();
    check("abort_pre_y", y3, 8'h10);
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("abort_y", y3, 0);
    check("abort_busy", b3, 0);
    check("abort_done", d3, 0);
    check("abort_ready", r3, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_nodone%0d", i), d3, 0);
      check($sformatf("abort_y_post%0d", i), y3, 0);
    end

    // N=4 plain decode
    a4 = 4'd15; en4 = 1; v4 = 1;
    tick();
    v4 = 0;
    check("n4_y", y4, 16'h8000);
    check("n4_vo", vo4, 1);
`else
    // scan_start ignored: N=4 with scan_start held high
    ss4 = 1;
    tick();
    check("n4_busy", b4, 0);
    check("n4_done", d4, 0);
    check("n4_ready", r4, 1);
    a4 = 4'd15; en4 = 1; v4 = 1;
    tick();
    v4 = 0;
    check("n4_y", y4, 16'h8000);
    check("n4_vo", vo4, 1);
    check("n4_busy2", b4, 0);
    tick();
    check("n4_y_after", y4, 0);
    check("n4_ready2", r4, 1);

    // N=3 request with scan_start is still accepted
    ss3 = 1; v3 = 1; a3 = 3'd5; en3 = 1;
    tick();
    ss3 = 0; v3 = 0;
    check("n3_y", y3, 8'h20);
    check("n3_vo", vo3, 1);
    check("n3_busy", b3, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 The block SHALL have parameter N, default 5: select width; output width is 2**N.
REQ-002 The block SHALL have parameter HOLD, default 0: 0 = one-cycle decode pulse, 1 = decoded value held.
REQ-003 The block SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port A  input  N  decode select.
REQ-006 The block SHALL have port enable  input  1  decode enable; 0 produces an all-zero result.
REQ-007 The block SHALL have port valid_i  input  1  decode request valid.
REQ-008 The block SHALL have port ready_o  output  1  decode request can be accepted.
REQ-009 The block SHALL have port scan_start  input  1  start a one-hot sweep of all outputs.
REQ-010 The block SHALL have port Y  output  2**N  registered one-hot result.
REQ-011 The block SHALL have port valid_o  output  1  Y carries a decode result this cycle.
REQ-012 The block SHALL have ports scan_busy and scan_done  output  1 each  sweep in progress / sweep finished.

Function
REQ-013 The block SHALL be fully synchronous on clock; reset is synchronous and active-high; Y, valid_o, scan_busy and scan_done SHALL all be registered outputs.
REQ-014 The block SHALL implement FSM states IDLE, SCAN and DONE.
REQ-015 The block SHALL assert ready_o = (state == IDLE) and not scan_start; ready_o is the only combinational output.
REQ-016 The block SHALL accept a request on an edge where valid_i and ready_o are both 1.
REQ-017 On acceptance, from the next cycle: Y = 1 << A if enable = 1, else Y = 0; valid_o = 1 for exactly one cycle; latency 1 cycle.
REQ-018 With HOLD = 0, in every IDLE cycle with no prior-edge acceptance, Y SHALL be 0.
REQ-019 With HOLD = 1, Y SHALL retain the last accepted value until the next acceptance, a sweep start or reset.
REQ-020 In IDLE, scan_start = 1 SHALL move the FSM to SCAN with index 0; scan_start SHALL win over a simultaneous valid_i, which is not accepted.
REQ-021 In SCAN, Y SHALL equal 1 << idx, scan_busy = 1 and valid_o = 0; idx SHALL increment once per cycle from 0 to 2**N - 1.
REQ-022 After the SCAN cycle with idx = 2**N - 1, the FSM SHALL enter DONE.
REQ-023 DONE SHALL last one cycle with Y = 0, scan_done = 1 and scan_busy = 0, then return to IDLE; a sweep therefore occupies 2**N + 1 cycles.
REQ-024 The block SHALL ignore scan_start and valid_i while in SCAN or DONE; there is no sweep restart.
REQ-025 The sweep index SHALL be N bits wide; its terminal value SHALL be detected without wrap-around, so no output bit is repeated.
REQ-026 A sweep SHALL clear any HOLD value; after DONE, Y SHALL remain 0 until the next acceptance.

Reset
REQ-027 When reset = 1 at an edge, the block SHALL set FSM = IDLE, idx = 0, Y = 0, valid_o = 0, scan_busy = 0 and scan_done = 0, with priority over all other inputs.
REQ-028 A reset during SCAN or DONE SHALL abort the sweep with no scan_done pulse.
REQ-029 ready_o SHALL be 1 in the first cycle after reset when scan_start = 0.

Configuration
REQ-030 The sweep SHALL be controlled by macro DECODER_SEQ_SCAN_EN.
REQ-031 With DECODER_SEQ_SCAN_EN defined, the block SHALL behave as REQ-014 to REQ-026.
REQ-032 Without DECODER_SEQ_SCAN_EN, no FSM or index logic SHALL be built; scan_start SHALL be ignored; scan_busy = scan_done = 0; ready_o = 1 constantly; decode behaviour (REQ-016 to REQ-019) SHALL be unchanged.

Verification
REQ-033 The bench SHALL cover: N=5, HOLD=0, reset, then A=7, enable=1, valid_i=1 for one cycle -> next cycle Y=32'h0000_0080 and valid_o=1; following cycle Y=0 and valid_o=0.
REQ-034 The bench SHALL cover: N=5, HOLD=1, accept A=3, then idle 4 cycles -> Y=32'h0000_0008 held all 4 cycles; accept A=3 with enable=0 -> Y=0 and valid_o=1.
REQ-035 The bench SHALL cover: N=3, macro defined, scan_start pulse -> Y = 01,02,04,...,80 over 8 cycles with scan_busy=1, then 1 cycle with scan_done=1 and Y=0, and ready_o=0 throughout the sweep.
REQ-036 The bench SHALL cover: N=3, scan_start and valid_i (A=5) on the same edge -> request not accepted, sweep starts with Y=01, and valid_o is never asserted.
REQ-037 The bench SHALL cover: N=3, reset asserted at sweep cycle 4 (Y=10) -> next cycle Y=0, scan_busy=0, no scan_done, ready_o=1.
REQ-038 The bench SHALL cover: N=4, macro undefined, scan_start held at 1 -> scan_busy=0, ready_o=1, and A=15 decodes to Y=16'h8000 with latency 1.
